// File: rtl/core_drain_monitor_if.sv
// Handshake bundle between the test event layer and the drain monitor.
// master: drives core_req/start_test/finish_req, observes status; slave: the monitor.
interface core_drain_monitor_if #(
    parameter int NUM_CORES = 32,
    parameter int CNT_W     = 16
);
    logic [NUM_CORES-1:0] core_req;
    logic                 start_test;
    logic                 finish_req;
    logic                 busy;
    logic                 test_finish;
    logic                 drain_timeout;
    logic [NUM_CORES-1:0] pending_mask;
    logic [CNT_W-1:0]     req_count;

    modport master (
        output core_req, start_test, finish_req,
        input  busy, test_finish, drain_timeout, pending_mask, req_count
    );

    modport slave (
        input  core_req, start_test, finish_req,
        output busy, test_finish, drain_timeout, pending_mask, req_count
    );
endinterface

// File: rtl/core_drain_monitor.sv
// End-of-test drain detector: after finish_req, waits for SETTLE_CYCLES quiet
// cycles on all core requests (test_finish) or flags a timeout (drain_timeout).
// Ports: clk, rst (async, active-high), mon (slave modport: core_req,
// start_test, finish_req in; busy, test_finish, drain_timeout, pending_mask,
// req_count out).
module core_drain_monitor #(
    parameter int NUM_CORES      = 32,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input logic                 clk,
    input logic                 rst,
    core_drain_monitor_if.slave mon
);
    localparam int QW  = $clog2(SETTLE_CYCLES + 1);
    localparam int DW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PCW = $clog2(NUM_CORES + 1);
    localparam int SW  = CNT_W + PCW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN,
        S_DONE,
        S_TIMEOUT
    } state_e;

    state_e               state_q, state_d;
    logic [QW-1:0]        quiet_cnt_q, quiet_cnt_d;
    logic [DW-1:0]        drain_cnt_q, drain_cnt_d;
    logic [NUM_CORES-1:0] req_prev_q;
    logic [NUM_CORES-1:0] pending_mask_q, pending_mask_d;
    logic [CNT_W-1:0]     req_count_q, req_count_d;

    logic                 quiet;
    logic [NUM_CORES-1:0] rise;
    logic [PCW-1:0]       rise_cnt;
    logic [SW-1:0]        cnt_sum;
    logic [CNT_W-1:0]     cnt_sat;
    logic                 done_hit;
    logic                 tout_hit;

    assign quiet = ~|mon.core_req;
    assign rise  = mon.core_req & ~req_prev_q;

    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            rise_cnt = rise_cnt + PCW'(rise[i]);
        end
    end

    // Widen before adding so the carry out of CNT_W signals saturation.
    assign cnt_sum = SW'(req_count_q) + SW'(rise_cnt);
    assign cnt_sat = (|cnt_sum[SW-1:CNT_W]) ? {CNT_W{1'b1}}
                                            : cnt_sum[CNT_W-1:0];

    assign done_hit = quiet && (quiet_cnt_q == QW'(SETTLE_CYCLES - 1));
    assign tout_hit = (drain_cnt_q == DW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d        = state_q;
        quiet_cnt_d    = quiet_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        pending_mask_d = pending_mask_q;
        req_count_d    = req_count_q;
        if (mon.start_test) begin
            state_d        = S_ACTIVE;
            quiet_cnt_d    = '0;
            drain_cnt_d    = '0;
            pending_mask_d = '0;
            req_count_d    = '0;
        end else begin
            case (state_q)
                S_ACTIVE: begin
                    req_count_d = cnt_sat;
                    if (mon.finish_req) begin
                        state_d     = S_DRAIN;
                        quiet_cnt_d = '0;
                        drain_cnt_d = '0;
                    end
                end
                S_DRAIN: begin
                    req_count_d = cnt_sat;
                    drain_cnt_d = drain_cnt_q + DW'(1);
                    quiet_cnt_d = quiet ? quiet_cnt_q + QW'(1) : '0;
                    // A settle window closing on the timeout edge wins.
                    if (done_hit) begin
                        state_d = S_DONE;
                    end else if (tout_hit) begin
                        state_d        = S_TIMEOUT;
                        pending_mask_d = mon.core_req;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            quiet_cnt_q    <= '0;
            drain_cnt_q    <= '0;
            req_prev_q     <= '0;
            pending_mask_q <= '0;
            req_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            quiet_cnt_q    <= quiet_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            req_prev_q     <= mon.core_req;
            pending_mask_q <= pending_mask_d;
            req_count_q    <= req_count_d;
        end
    end

    assign mon.busy          = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
    assign mon.test_finish   = (state_q == S_DONE);
    assign mon.drain_timeout = (state_q == S_TIMEOUT);
    assign mon.pending_mask  = pending_mask_q;
    assign mon.req_count     = req_count_q;
endmodule

// File: tb/tb_core_drain_monitor.sv
// Self-checking bench for core_drain_monitor: directed scenarios plus random
// traffic, compared every cycle against a behavioural drain model.
module tb_core_drain_monitor;
    localparam int NC     = 32;
    localparam int SETTLE = 4;
    localparam int TMO    = 1024;
    localparam int CW     = 16;
    localparam int CMAX   = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    core_drain_monitor_if #(.NUM_CORES(NC), .CNT_W(CW)) bus ();

    core_drain_monitor #(
        .NUM_CORES(NC), .SETTLE_CYCLES(SETTLE),
        .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mon(bus)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Behavioural model: flags for the test phase, plain integer counters.
    bit          m_running, m_draining, m_done, m_tout;
    int          m_count, m_quiet_run, m_drain_cycles;
    logic [NC-1:0] m_prev, m_pend;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > CMAX) ? CMAX : a + b;
    endfunction

    task automatic m_reset();
        m_running = 0; m_draining = 0; m_done = 0; m_tout = 0;
        m_count = 0; m_quiet_run = 0; m_drain_cycles = 0;
        m_prev = '0; m_pend = '0;
    endtask

    task automatic m_step(input logic [NC-1:0] req, input bit start,
                          input bit fin);
        int rises;
        rises = $countones(req & ~m_prev);
        if (start) begin
            m_running = 1; m_draining = 0; m_done = 0; m_tout = 0;
            m_count = 0; m_pend = '0; m_quiet_run = 0; m_drain_cycles = 0;
        end else if (m_running && !m_draining) begin
            m_count = sat_add(m_count, rises);
            if (fin) begin
                m_draining = 1; m_quiet_run = 0; m_drain_cycles = 0;
            end
        end else if (m_draining) begin
            m_count = sat_add(m_count, rises);
            m_drain_cycles++;
            m_quiet_run = (req == '0) ? m_quiet_run + 1 : 0;
            if (m_quiet_run == SETTLE) begin
                m_done = 1; m_running = 0; m_draining = 0;
            end else if (m_drain_cycles == TMO) begin
                m_tout = 1; m_running = 0; m_draining = 0; m_pend = req;
            end
        end
        m_prev = req;
    endtask

    task automatic check_all();
        check("busy", bus.busy, m_running);
        check("test_finish", bus.test_finish, m_done);
        check("drain_timeout", bus.drain_timeout, m_tout);
        check("pending_mask", bus.pending_mask, m_pend);
        check("req_count", bus.req_count, m_count);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) m_reset();
        else m_step(bus.core_req, bus.start_test, bus.finish_req);
        @(negedge clk);
        check_all();
    endtask

    task automatic pulse_start();
        bus.start_test = 1'b1;
        tick();
        bus.start_test = 1'b0;
    endtask

    task automatic pulse_finish();
        bus.finish_req = 1'b1;
        tick();
        bus.finish_req = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int used);
        used = 0;
        while (!bus.test_finish && !bus.drain_timeout && used < budget) begin
            tick();
            used++;
        end
        if (!bus.test_finish && !bus.drain_timeout)
            check("wait_bound", 1'b0, 1'b1);
    endtask

    initial begin
        int used;
        bus.core_req = '0;
        bus.start_test = 1'b0;
        bus.finish_req = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        check_all();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_count", bus.req_count, 0);
        rst = 1'b0;

        // IDLE ignores finish_req and activity.
        bus.core_req = 32'hF;
        pulse_finish();
        bus.core_req = '0;
        tick();
        check("idle_ignore", bus.busy, 1'b0);

        // Three single pulses, then a clean drain.
        pulse_start();
        for (int c = 1; c <= 3; c++) begin
            bus.core_req = '0;
            bus.core_req[c] = 1'b1;
            tick();
            bus.core_req = '0;
            tick();
        end
        pulse_finish();
        for (int k = 1; k <= SETTLE; k++) begin
            tick();
            if (k < SETTLE) check("fin_early", bus.test_finish, 1'b0);
        end
        check("fin_latency", bus.test_finish, 1'b1);
        check("s1_count", bus.req_count, 3);
        check("s1_busy", bus.busy, 1'b0);

        // Core 5 held for 10 drain cycles.
        pulse_start();
        pulse_finish();
        bus.core_req = 32'h20;
        repeat (10) tick();
        bus.core_req = '0;
        wait_end(100, used);
        check("glitch_latency", used, SETTLE);
        check("glitch_tout", bus.drain_timeout, 1'b0);

        // Cores 17 and 31 stuck.
        pulse_start();
        pulse_finish();
        bus.core_req = 32'h8002_0000;
        repeat (TMO - 1) tick();
        check("tout_early", bus.drain_timeout, 1'b0);
        tick();
        check("tout_flag", bus.drain_timeout, 1'b1);
        check("tout_mask", bus.pending_mask, 64'h8002_0000);
        check("tout_fin", bus.test_finish, 1'b0);
        bus.core_req = 32'h1;
        repeat (3) tick();
        check("tout_sticky", bus.drain_timeout, 1'b1);

        // Quiet window completes on the timeout edge.
        pulse_start();
        pulse_finish();
        for (int k = 1; k <= TMO - SETTLE; k++) begin
            bus.core_req = $urandom() | 32'h1;
            tick();
        end
        bus.core_req = '0;
        repeat (SETTLE) tick();
        check("tie_fin", bus.test_finish, 1'b1);
        check("tie_tout", bus.drain_timeout, 1'b0);

        // start + finish together while DONE.
        bus.start_test = 1'b1;
        bus.finish_req = 1'b1;
        tick();
        bus.start_test = 1'b0;
        bus.finish_req = 1'b0;
        check("restart_busy", bus.busy, 1'b1);
        check("restart_fin", bus.test_finish, 1'b0);
        check("restart_count", bus.req_count, 0);
        bus.core_req = 32'h0000_0F0F;
        tick();
        bus.core_req = '0;
        pulse_finish();
        wait_end(100, used);
        check("restart_done", bus.test_finish, 1'b1);

        // Random traffic rounds.
        for (int r = 0; r < 20; r++) begin
            pulse_start();
            for (int k = 0; k < $urandom_range(1, 40); k++) begin
                bus.core_req = ($urandom_range(0, 2) == 0) ? $urandom() : '0;
                bus.finish_req = ($urandom_range(0, 15) == 0);
                tick();
            end
            bus.finish_req = 1'b1;
            tick();
            bus.finish_req = 1'b0;
            for (int k = 0; k < 200 && !bus.test_finish; k++) begin
                bus.core_req = ($urandom_range(0, 3) == 0) ? $urandom() : '0;
                bus.finish_req = ($urandom_range(0, 7) == 0);
                tick();
            end
            bus.finish_req = 1'b0;
            bus.core_req = '0;
            wait_end(TMO + 10, used);
        end

        // Reset mid-drain.
        pulse_start();
        pulse_finish();
        bus.core_req = 32'h3;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1 m_reset();
        check_all();
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_count", bus.req_count, 0);
        tick();
        rst = 1'b0;
        bus.core_req = '0;
        tick();
        check("post_rst_fin", bus.test_finish, 1'b0);

        // Saturation of the edge counter.
        pulse_start();
        for (int i = 0; i < 5000; i++) begin
            bus.core_req = (i % 2 == 0) ? '1 : '0;
            tick();
        end
        check("sat_count", bus.req_count, CMAX);
        bus.core_req = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
